serial_adder: RTL

//   Multi-bit bit-serial adder built around the existing 1-bit full-adder cell.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_onebitadder.sv | 17 +
 rtl/serial_adder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t : FSM encoding (S_IDLE=0, S_RUN=1, S_DONE=2)
//   cnt_width() : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter must hold WIDTH-1 for every legal WIDTH, including WIDTH=1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_onebitadder.sv
// One-bit full-adder cell, purely combinational.
// Ports:
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   c         : carry-out bit
module onebitadder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: loads two WIDTH-bit operands and a carry-in on start,
// pushes one bit pair per clock (LSB first) through a single full-adder
// cell with a registered carry, then presents {cout,sum} with a one-cycle
// done pulse.
// Ports:
//   clk   : clock, rising-edge
//   rst   : synchronous active-high reset (overrides start, aborts RUN)
//   start : load request, accepted only in IDLE or DONE
//   a_in  : operand A, sampled on the accepting edge
//   b_in  : operand B, sampled on the accepting edge
//   cin   : carry-in, sampled on the accepting edge
//   busy  : high while in RUN
//   done  : high for the single cycle in DONE
//   sum   : result, held until the next completion or reset
//   cout  : final carry-out, held with sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;
    logic             unused_res_lsb;

    onebitadder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (cnt == CNT_LAST);

    // New sum bits enter at the MSB so that after WIDTH shifts the first
    // (LSB) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_nx = fa_s;
        end else begin : g_res_wn
            assign res_nx = {fa_s, res_sh[WIDTH-1:1]};
        end
    endgenerate

    // The oldest result bit is always shifted out and never consumed.
    assign unused_res_lsb = res_sh[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            carry  <= cin;
            cnt    <= '0;
            res_sh <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
            carry  <= fa_c;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= res_nx;
                cout <= fa_c;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
